// File: rtl/core_wb_pkg.sv
// core_wb_pkg: shared types and helpers for the core-to-Wishbone bridge.
//
// Contents:
//   state_t     - bridge FSM states (IDLE, BUS, RESP)
//   ERR_FILL    - fill bit replicated across rsp_rdata on a watchdog timeout
//   grant_width - bits needed for a port index, never less than 1
package core_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Replicated to DATA_WIDTH at the use site so the package stays width-agnostic.
    localparam logic ERR_FILL = 1'b1;

    function automatic int grant_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/core_wb_rr_arbiter.sv
// core_wb_rr_arbiter: combinational round-robin arbiter.
//
// The search starts one past the previous winner and wraps modulo NUM_PORTS,
// so the port granted last has the lowest priority next time.
//
// Ports:
//   i_req        [NUM_PORTS-1:0] request vector
//   i_last_grant [GW-1:0]        index of the previous winner
//   o_grant      [GW-1:0]        index of the winner (meaningful when o_any=1)
//   o_any                        at least one request is present
module core_wb_rr_arbiter
    import core_wb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int GW        = grant_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [GW-1:0]        i_last_grant,
    output logic [GW-1:0]        o_grant,
    output logic                 o_any
);

    always_comb begin
        int w_idx;
        w_idx   = 0;
        o_grant = i_last_grant;
        o_any   = |i_req;
        // Walk from the farthest offset down to the nearest one; the nearest
        // requesting port is written last and therefore wins.
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_idx = (int'(i_last_grant) + i) % NUM_PORTS;
            if (i_req[w_idx[GW-1:0]]) begin
                o_grant = w_idx[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/core_wb_bridge.sv
// core_wb_bridge: multiplexes NUM_PORTS core request channels onto a single
// Wishbone classic master port.
//
// Flow: IDLE picks a port round-robin and latches its request, BUS drives the
// Wishbone cycle until wb_ack, RESP pulses req_ready for the granted port.
//
// Optional feature: define CORE_WB_TIMEOUT_EN to compile in a watchdog that
// ends a BUS phase after TIMEOUT_CYCLES cycles without wb_ack, pulsing
// req_err with req_ready and returning all-ones read data.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_we [NUM_PORTS]   per-port request and write flag
//   req_addr/req_wdata             packed per-port address/data, port i in slice i
//   req_ready/req_err [NUM_PORTS]  one-cycle completion / timeout pulses
//   rsp_rdata                      read data, valid while req_ready is high
//   wb_cyc/wb_stb/wb_we            Wishbone controls
//   wb_addr/wb_data_out            Wishbone address and write data
//   wb_data_in/wb_ack              Wishbone read data and acknowledge
//   dbg_state                      current FSM state for observation
//
// Handshake: a requester holds req_valid/we/addr/wdata until its req_ready
// pulse; the bridge latches them at grant, so dropping req_valid during BUS
// does not abort the cycle. A req_valid seen in IDLE is always a new request.
module core_wb_bridge
    import core_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             req_err,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             wb_cyc,
    output logic                             wb_stb,
    output logic                             wb_we,
    output logic [ADDR_WIDTH-1:0]            wb_addr,
    output logic [DATA_WIDTH-1:0]            wb_data_out,
    input  logic [DATA_WIDTH-1:0]            wb_data_in,
    input  logic                             wb_ack,
    output state_t                           dbg_state
);

    localparam int            GW          = grant_width(NUM_PORTS);
    // Last grant starts at the top port so port 0 wins first after reset.
    localparam logic [GW-1:0] RESET_GRANT = GW'(NUM_PORTS - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [GW-1:0]           r_grant;
    logic [GW-1:0]           w_arb_grant;
    logic                    w_arb_any;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [NUM_PORTS-1:0]    w_port_sel;
    logic                    w_expire;

    core_wb_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_grant),
        .o_grant      (w_arb_grant),
        .o_any        (w_arb_any)
    );

    assign w_port_sel  = NUM_PORTS'(1) << r_grant;
    assign wb_we       = r_we;
    assign wb_addr     = r_addr;
    assign wb_data_out = r_wdata;
    assign rsp_rdata   = r_rdata;
    assign dbg_state   = r_state;

`ifdef CORE_WB_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_err;

    // Expiry is suppressed by a coincident wb_ack so the real completion wins.
    assign w_expire = (r_state == BUS) && !wb_ack &&
                      (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign req_err  = ((r_state == RESP) && r_err) ? w_port_sel : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            // Held at zero while idle, so it is clear on the first BUS cycle.
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (r_state == BUS) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if ((r_state == BUS) && (w_next == RESP)) begin
                r_err <= w_expire;
            end
        end
    end
`else
    assign w_expire = 1'b0;
    assign req_err  = '0;
`endif

    always_comb begin
        w_next    = r_state;
        wb_cyc    = 1'b0;
        wb_stb    = 1'b0;
        req_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    w_next = BUS;
                end
            end
            BUS: begin
                wb_cyc = 1'b1;
                wb_stb = 1'b1;
                if (wb_ack || w_expire) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                req_ready = w_port_sel;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= RESET_GRANT;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && w_arb_any) begin
                r_grant <= w_arb_grant;
                r_we    <= req_we[w_arb_grant];
                r_addr  <= req_addr[w_arb_grant*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata <= req_wdata[w_arb_grant*DATA_WIDTH +: DATA_WIDTH];
            end
            if (r_state == BUS) begin
                if (wb_ack) begin
                    r_rdata <= wb_data_in;
                end else if (w_expire) begin
                    r_rdata <= {DATA_WIDTH{ERR_FILL}};
                end
            end
        end
    end

endmodule

// File: tb/tb_core_wb_bridge.sv
// tb_core_wb_bridge: self-checking bench for core_wb_bridge (NUM_PORTS=2,
// TIMEOUT_CYCLES=4). Works with or without CORE_WB_TIMEOUT_EN defined.
module tb_core_wb_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NP  = 2;
    localparam int TMO = 4;
`ifdef CORE_WB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                clk = 1'b0;
    logic                reset;
    logic [NP-1:0]       req_valid;
    logic [NP-1:0]       req_we;
    logic [NP*AW-1:0]    req_addr;
    logic [NP*DW-1:0]    req_wdata;
    logic [NP-1:0]       req_ready;
    logic [NP-1:0]       req_err;
    logic [DW-1:0]       rsp_rdata;
    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_we;
    logic [AW-1:0]       wb_addr;
    logic [DW-1:0]       wb_data_out;
    logic [DW-1:0]       wb_data_in;
    logic                wb_ack;
    core_wb_pkg::state_t dbg_state;

    always #5 clk = ~clk;

    core_wb_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NUM_PORTS      (NP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .req_err     (req_err),
        .rsp_rdata   (rsp_rdata),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data_out (wb_data_out),
        .wb_data_in  (wb_data_in),
        .wb_ack      (wb_ack),
        .dbg_state   (dbg_state)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    int            model_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Round-robin rule: first requesting port after the last winner, wrapping.
    function automatic int model_pick(input logic [NP-1:0] v);
        for (int k = 1; k <= NP; k++) begin
            if (v[(model_last + k) % NP]) return (model_last + k) % NP;
        end
        return -1;
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge where the DUT is in IDLE; returns at the negedge of
    // the IDLE cycle following RESP. dly = BUS cycles before the ack cycle.
    task automatic run_txn(input logic [NP-1:0] v, input logic [NP-1:0] we,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input int dly, input logic [DW-1:0] rd,
                           input int exp_g, input bit drop);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [DW-1:0] exp_d;
        bit            ewe;
        bit            eto;
        bit            has_data;
        int            blen;
        req_valid  = v;
        req_we     = we;
        req_addr   = {a1, a0};
        req_wdata  = {d1, d0};
        wb_data_in = rd;
        wb_ack     = 1'b0;
        ea  = req_addr[exp_g*AW +: AW];
        ed  = req_wdata[exp_g*DW +: DW];
        ewe = we[exp_g];
        eto  = TMO_EN && (dly + 1 > TMO);
        blen = eto ? TMO : dly + 1;
        has_data = !ewe || eto;
        if (has_data) exp_q.push_back(eto ? {DW{1'b1}} : rd);
        model_last = exp_g;
        check("idle_cyc", {31'd0, wb_cyc}, 0);
        check("idle_ready", {62'd0, req_ready}, 0);
        for (int n = 1; n <= blen; n++) begin
            @(negedge clk);
            check("bus_cyc_stb", {62'd0, wb_cyc, wb_stb}, 64'd3);
            check("bus_we", {63'd0, wb_we}, {63'd0, ewe});
            check("bus_addr", {32'd0, wb_addr}, {32'd0, ea});
            check("bus_wdata", {32'd0, wb_data_out}, {32'd0, ed});
            check("bus_ready", {62'd0, req_ready}, 0);
            if (drop && n == 1) req_valid = '0;
            wb_ack = (n == dly + 1);
        end
        @(negedge clk);
        wb_ack = 1'b0;
        check("resp_ready", {62'd0, req_ready}, 64'd1 << exp_g);
        check("resp_err", {62'd0, req_err}, eto ? (64'd1 << exp_g) : 64'd0);
        check("resp_cyc", {63'd0, wb_cyc}, 0);
        exp_d = '0;
        if (has_data) begin
            exp_d = exp_q.pop_front();
            check("resp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_d});
        end
        @(negedge clk);
        check("post_ready", {62'd0, req_ready}, 0);
        check("post_err", {62'd0, req_err}, 0);
        if (has_data) check("hold_rdata", {32'd0, rsp_rdata}, {32'd0, exp_d});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NP-1:0] v;
        logic [NP-1:0] we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] rd;
        int            dly;
        int            g;
    } vec_t;

    vec_t tbl[6];
    int   cont_g[4];

    initial begin
        // Grants hand-derived from reset (last grant = port 1).
        tbl[0] = '{v:2'b01, we:2'b00, a0:32'h100, a1:32'h0, d0:32'h0, d1:32'h0,
                   rd:32'hDEADBEEF, dly:2, g:0};
        tbl[1] = '{v:2'b10, we:2'b10, a0:32'h0, a1:32'h200, d0:32'h0, d1:32'h12345678,
                   rd:32'h0BADF00D, dly:1, g:1};
        tbl[2] = '{v:2'b11, we:2'b00, a0:32'h300, a1:32'h304, d0:32'h0, d1:32'h0,
                   rd:32'hA5A5A5A5, dly:0, g:0};
        tbl[3] = '{v:2'b11, we:2'b01, a0:32'h400, a1:32'h404, d0:32'h11, d1:32'h22,
                   rd:32'h5A5A5A5A, dly:0, g:1};
        tbl[4] = '{v:2'b10, we:2'b00, a0:32'h500, a1:32'h504, d0:32'h0, d1:32'h0,
                   rd:32'hCAFEF00D, dly:3, g:1};
        tbl[5] = '{v:2'b01, we:2'b00, a0:32'h600, a1:32'h604, d0:32'h0, d1:32'h0,
                   rd:32'h00C0FFEE, dly:0, g:0};
        cont_g = '{0, 1, 0, 1};

        reset      = 1'b1;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        wb_data_in = 32'hFFFF0000;
        wb_ack     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {59'd0, wb_cyc, wb_stb, wb_we, req_ready}, 0);
        check("rst_err", {62'd0, req_err}, 0);
        check("rst_rdata", {32'd0, rsp_rdata}, 0);
        check("rst_addr", {32'd0, wb_addr}, 0);
        check("rst_wdata", {32'd0, wb_data_out}, 0);
        check("rst_state", {62'd0, dbg_state}, {62'd0, core_wb_pkg::IDLE});
        reset      = 1'b0;
        model_last = NP - 1;

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
                    tbl[i].dly, tbl[i].rd, tbl[i].g, 1'b0);
        end

        // Stray ack in IDLE is ignored.
        req_valid = '0;
        wb_ack    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_cyc", {63'd0, wb_cyc}, 0);
            check("stray_ready", {62'd0, req_ready}, 0);
            check("stray_state", {62'd0, dbg_state}, {62'd0, core_wb_pkg::IDLE});
        end
        wb_ack = 1'b0;

        // Requester drops req_valid in the first BUS cycle; cycle still completes.
        run_txn(2'b01, 2'b00, 32'h700, 32'h704, 32'h0, 32'h0, 2, 32'h13579BDF,
                model_pick(2'b01), 1'b1);

        // No ack for a long time (times out when the watchdog is built in),
        // then an ack landing on the expiry cycle.
        run_txn(2'b01, 2'b00, 32'h800, 32'h804, 32'h0, 32'h0, 10, 32'h2468ACE0,
                model_pick(2'b01), 1'b0);
        run_txn(2'b01, 2'b00, 32'h900, 32'h904, 32'h0, 32'h0, TMO - 1, 32'h89ABCDEF,
                model_pick(2'b01), 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic [NP-1:0] rv;
            rv = NP'($urandom_range(1, 3));
            run_txn(rv, NP'($urandom), $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 5), $urandom, model_pick(rv),
                    ($urandom_range(0, 3) == 0));
        end

        // Reset in the second BUS cycle aborts without a req_ready pulse.
        req_valid = 2'b10;
        req_we    = 2'b00;
        req_addr  = {32'hA00, 32'hB00};
        @(negedge clk);
        check("rb_bus1_cyc", {63'd0, wb_cyc}, 1);
        @(negedge clk);
        check("rb_bus2_cyc", {63'd0, wb_cyc}, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rb_cyc", {63'd0, wb_cyc}, 0);
        check("rb_ready", {62'd0, req_ready}, 0);
        check("rb_state", {62'd0, dbg_state}, {62'd0, core_wb_pkg::IDLE});
        check("rb_addr", {32'd0, wb_addr}, 0);
        check("rb_rdata", {32'd0, rsp_rdata}, 0);
        reset      = 1'b0;
        model_last = NP - 1;

        // Contention after reset: both held valid, immediate ack, grants alternate.
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, 2'b00, 32'hC00 + i, 32'hD00 + i, 32'h0, 32'h0, 0,
                    32'h1000 + i, cont_g[i], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
